// File: rtl/alarm_clock_multi.sv
// Time-of-day core with N programmable alarm slots, ring timeout and snooze.
// Commands are one-cycle pulses; tick is a one-cycle 1 Hz enable.
module alarm_clock_multi #(
    parameter int unsigned N_ALARM    = 4,
    parameter int unsigned H_MOD      = 24,
    parameter int unsigned M_MOD      = 60,
    parameter int unsigned S_MOD      = 60,
    parameter int unsigned RING_LEN   = 30,
    parameter int unsigned SNOOZE_LEN = 300,
    localparam int unsigned IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          en,
    input  logic          set_time,
    input  logic          wr_alarm,
    input  logic [IW-1:0] alarm_idx,
    input  logic          alarm_en_in,
    input  logic [5:0]    in_h,
    input  logic [5:0]    in_m,
    input  logic [5:0]    in_s,
    input  logic          stop,
    input  logic          snooze,
    output logic [5:0]    out_h,
    output logic [5:0]    out_m,
    output logic [5:0]    out_s,
    output logic [N_ALARM-1:0] alarm_on,
    output logic          alarming,
    output logic          snoozing,
    output logic [IW-1:0] ring_idx,
    output logic          err
);

    localparam int unsigned RW = $clog2(RING_LEN + 1);
    localparam int unsigned SW = $clog2(SNOOZE_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [RW-1:0] ring_cnt, ring_cnt_next;
    logic [SW-1:0] snz_cnt, snz_cnt_next;
    logic [IW-1:0] ring_idx_next;

    logic [5:0] slot_h [N_ALARM];
    logic [5:0] slot_m [N_ALARM];
    logic [5:0] slot_s [N_ALARM];

    logic          tick_run, adv, match_pending;
    logic          time_ok, wr_ok, kill;
    logic          s_wrap, m_wrap, h_wrap;
    logic          hit;
    logic [IW-1:0] hit_idx;

    // Input range checks shared by set_time and wr_alarm
    always_comb begin
        time_ok = ({1'b0, in_h} < 7'(H_MOD)) &&
                  ({1'b0, in_m} < 7'(M_MOD)) &&
                  ({1'b0, in_s} < 7'(S_MOD));
        wr_ok   = time_ok && (32'(alarm_idx) < N_ALARM);
    end

    assign tick_run = tick & en;
    assign adv      = tick_run & ~set_time;
    assign s_wrap   = (out_s == 6'(S_MOD - 1));
    assign m_wrap   = (out_m == 6'(M_MOD - 1));
    assign h_wrap   = (out_h == 6'(H_MOD - 1));
    // A valid write that disables the active slot aborts ring/snooze
    assign kill     = wr_alarm & wr_ok & ~alarm_en_in & (alarm_idx == ring_idx);

    // Timekeeping, error pulse and match-evaluation strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_h         <= '0;
            out_m         <= '0;
            out_s         <= '0;
            match_pending <= 1'b0;
            err           <= 1'b0;
        end else begin
            err           <= (set_time & ~time_ok) | (wr_alarm & ~wr_ok);
            match_pending <= adv;
            if (set_time) begin
                if (time_ok) begin
                    out_h <= in_h;
                    out_m <= in_m;
                    out_s <= in_s;
                end
            end else if (adv) begin
                out_s <= s_wrap ? 6'd0 : out_s + 6'd1;
                if (s_wrap) begin
                    out_m <= m_wrap ? 6'd0 : out_m + 6'd1;
                    if (m_wrap) begin
                        out_h <= h_wrap ? 6'd0 : out_h + 6'd1;
                    end
                end
            end
        end
    end

    // Alarm slot table
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_on <= '0;
            for (int i = 0; i < int'(N_ALARM); i++) begin
                slot_h[i] <= '0;
                slot_m[i] <= '0;
                slot_s[i] <= '0;
            end
        end else if (wr_alarm && wr_ok) begin
            slot_h[alarm_idx]   <= in_h;
            slot_m[alarm_idx]   <= in_m;
            slot_s[alarm_idx]   <= in_s;
            alarm_on[alarm_idx] <= alarm_en_in;
        end
    end

    // Descending scan so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(N_ALARM) - 1; i >= 0; i--) begin
            if (alarm_on[i] && slot_h[i] == out_h &&
                slot_m[i] == out_m && slot_s[i] == out_s) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            ring_idx <= '0;
            alarming <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_next;
            ring_cnt <= ring_cnt_next;
            snz_cnt  <= snz_cnt_next;
            ring_idx <= ring_idx_next;
            alarming <= (state_next == RINGING);
            snoozing <= (state_next == SNOOZED);
        end
    end

    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;
        ring_idx_next = ring_idx;
        case (state)
            IDLE: begin
                if (match_pending && hit) begin
                    state_next    = RINGING;
                    ring_idx_next = hit_idx;
                    ring_cnt_next = RW'(RING_LEN);
                end
            end
            RINGING: begin
                if (stop || kill) begin
                    state_next = IDLE;
                end else if (snooze) begin
                    state_next   = SNOOZED;
                    snz_cnt_next = SW'(SNOOZE_LEN);
                end else if (tick_run && ring_cnt != '0) begin
                    ring_cnt_next = ring_cnt - RW'(1);
                    if (ring_cnt == RW'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            SNOOZED: begin
                if (stop || kill) begin
                    state_next = IDLE;
                end else if (tick_run && snz_cnt != '0) begin
                    snz_cnt_next = snz_cnt - SW'(1);
                    if (snz_cnt == SW'(1)) begin
                        state_next    = RINGING;
                        ring_cnt_next = RW'(RING_LEN);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
